// File: rtl/riscv_result_monitor.sv
// riscv_result_monitor: passive snooper on the data-memory write bus that collects
// self-check results, watches for the end-of-test sentinel and enforces a timeout.
// Optional feature macro RESULT_MON_STAMP_EN: per-slot first-capture cycle stamps.
module riscv_result_monitor #(
   parameter int unsigned NUM_TESTS      = 13,
   parameter logic [31:0] RESULT_BASE    = 32'h0000_0100,
   parameter logic [31:0] DONE_ADDR      = 32'h0000_01FC,
   parameter logic [31:0] DONE_MAGIC     = 32'h600D_600D,
   parameter int unsigned TIMEOUT_CYCLES = 2000,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned IDX_W          = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [31:0]          d_mem_addr,
   input  logic [31:0]          d_mem_wdata,
   input  logic [3:0]           d_mem_wen,
   input  logic [IDX_W-1:0]     query_idx,
   output logic [31:0]          query_value,
   output logic [CNT_W-1:0]     query_stamp,
   output logic [NUM_TESTS-1:0] written_mask,
   output logic [NUM_TESTS-1:0] fail_mask,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [1:0]           state,
   output logic                 done,
   output logic                 timeout,
   output logic                 pass,
   output logic                 err_write
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   localparam logic [31:0]      WIN_END      = RESULT_BASE + 32'(4 * NUM_TESTS);
   localparam logic [CNT_W-1:0] LAST_RUN_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [31:0]      query_value_q;

   logic run, full_word, in_window, malformed, sentinel;

   logic [31:0] slot_q    [NUM_TESTS];
   logic        written_q [NUM_TESTS];
   logic        fail_q    [NUM_TESTS];

   assign run       = (state_q == ST_RUN);
   assign full_word = (d_mem_wen == 4'hF);
   assign in_window = (d_mem_addr >= RESULT_BASE) && (d_mem_addr < WIN_END);
   // Any partial or misaligned store landing in the window is a test-program bug.
   assign malformed = run && (d_mem_wen != 4'h0) && in_window
                      && (!full_word || (d_mem_addr[1:0] != 2'b00));
   assign sentinel  = run && full_word && (d_mem_addr == DONE_ADDR)
                      && (d_mem_wdata == DONE_MAGIC);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            if (malformed) err_d = 1'b1;
            if (sentinel)                   state_d = ST_DONE;
            else if (cnt_q == LAST_RUN_CNT) state_d = ST_TIMEOUT;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Every aligned word in the window maps to exactly one slot address.
   generate
      for (genvar gi = 0; gi < NUM_TESTS; gi++) begin : g_slot
         localparam logic [31:0] SLOT_ADDR = RESULT_BASE + 32'(4 * gi);
         logic hit;
         assign hit = run && full_word && (d_mem_addr == SLOT_ADDR);

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               slot_q[gi]    <= '0;
               written_q[gi] <= 1'b0;
               fail_q[gi]    <= 1'b0;
            end else if (hit) begin
               slot_q[gi]    <= d_mem_wdata;
               written_q[gi] <= 1'b1;
               fail_q[gi]    <= (d_mem_wdata != 32'h0);
            end
         end

         assign written_mask[gi] = written_q[gi];
         assign fail_mask[gi]    = fail_q[gi];
      end
   endgenerate

   logic [31:0] rd_value;
   always_comb begin
      rd_value = '0;
      for (int i = 0; i < NUM_TESTS; i++) begin
         if (query_idx == IDX_W'(i)) rd_value = slot_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) query_value_q <= '0;
      else        query_value_q <= rd_value;
   end

`ifdef RESULT_MON_STAMP_EN
   logic [CNT_W-1:0] stamp_q [NUM_TESTS];
   logic [CNT_W-1:0] query_stamp_q;
   logic [CNT_W-1:0] rd_stamp;

   generate
      for (genvar gi = 0; gi < NUM_TESTS; gi++) begin : g_stamp
         // Only the first capture is stamped; rewrites keep the original cycle.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               stamp_q[gi] <= '0;
            end else if (g_slot[gi].hit && !written_q[gi]) begin
               stamp_q[gi] <= cnt_q;
            end
         end
      end
   endgenerate

   always_comb begin
      rd_stamp = '0;
      for (int i = 0; i < NUM_TESTS; i++) begin
         if (query_idx == IDX_W'(i) && written_q[i]) rd_stamp = stamp_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) query_stamp_q <= '0;
      else        query_stamp_q <= rd_stamp;
   end

   assign query_stamp = query_stamp_q;
`else
   assign query_stamp = '0;
`endif

   assign query_value = query_value_q;
   assign cycle_count = cnt_q;
   assign state       = state_q;
   assign done        = (state_q == ST_DONE);
   assign timeout     = (state_q == ST_TIMEOUT);
   assign err_write   = err_q;
   assign pass        = done && (&written_mask) && !(|fail_mask) && !err_q;

endmodule

// File: tb/tb_riscv_result_monitor.sv
// Self-checking bench for riscv_result_monitor: directed test-plan scenarios plus
// randomized bus traffic, compared every cycle against an array-based model.
module tb_riscv_result_monitor;

   localparam int          N     = 13;
   localparam logic [31:0] BASE  = 32'h0000_0100;
   localparam logic [31:0] DADDR = 32'h0000_01FC;
   localparam logic [31:0] MAGIC = 32'h600D_600D;
   localparam int          TO    = 2000;

   logic        clk = 1'b0;
   logic        rst_n, enable;
   logic [31:0] addr, wdata;
   logic [3:0]  wen;
   logic [5:0]  qidx;

   logic [31:0]  query_value;
   logic [15:0]  query_stamp;
   logic [N-1:0] written_mask, fail_mask;
   logic [15:0]  cycle_count;
   logic [1:0]   state;
   logic         done, timeout, pass, err_write;

   always #5 clk = ~clk;

   riscv_result_monitor dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .d_mem_addr   (addr),
      .d_mem_wdata  (wdata),
      .d_mem_wen    (wen),
      .query_idx    (qidx),
      .query_value  (query_value),
      .query_stamp  (query_stamp),
      .written_mask (written_mask),
      .fail_mask    (fail_mask),
      .cycle_count  (cycle_count),
      .state        (state),
      .done         (done),
      .timeout      (timeout),
      .pass         (pass),
      .err_write    (err_write)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model
   int          m_state;
   int          m_cnt;
   bit          m_err;
   logic [31:0] m_slot  [N];
   bit          m_wr    [N];
   bit          m_fl    [N];
   int          m_stamp [N];
   logic [31:0] m_qv;
   logic [15:0] m_qs;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [31:0] nqv;
      logic [15:0] nqs;
      bit          inwin, sent;
      int          i;
      nqv = 32'h0;
      nqs = 16'h0;
      if (qidx < N) begin
         nqv = m_slot[qidx];
         if (m_wr[qidx]) nqs = 16'(m_stamp[qidx]);
      end
      if (!rst_n) begin
         m_state = 0; m_cnt = 0; m_err = 0; m_qv = 0; m_qs = 0;
         for (int k = 0; k < N; k++) begin
            m_slot[k] = 0; m_wr[k] = 0; m_fl[k] = 0; m_stamp[k] = 0;
         end
         return;
      end
      m_qv = nqv;
`ifdef RESULT_MON_STAMP_EN
      m_qs = nqs;
`else
      m_qs = 16'h0;
`endif
      if (m_state == 0) begin
         if (enable) m_state = 1;
      end else if (m_state == 1) begin
         inwin = (addr >= BASE) && (addr < BASE + 4 * N);
         sent  = (wen == 4'hF) && (addr == DADDR) && (wdata == MAGIC);
         if (inwin && wen == 4'hF && addr % 4 == 0) begin
            i = int'((addr - BASE) / 4);
            if (!m_wr[i]) m_stamp[i] = m_cnt;
            m_slot[i] = wdata;
            m_wr[i]   = 1;
            m_fl[i]   = (wdata != 0);
         end else if (inwin && wen != 4'h0) begin
            m_err = 1;
         end
         if (sent)               m_state = 2;
         else if (m_cnt == TO-1) m_state = 3;
         m_cnt++;
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] ew, ef;
      bit           ep;
      for (int k = 0; k < N; k++) begin
         ew[k] = m_wr[k];
         ef[k] = m_fl[k];
      end
      ep = (m_state == 2) && (&ew) && !(|ef) && !m_err;
      chk("state",        state,        m_state[1:0]);
      chk("cycle_count",  cycle_count,  m_cnt[15:0]);
      chk("written_mask", written_mask, ew);
      chk("fail_mask",    fail_mask,    ef);
      chk("err_write",    err_write,    m_err);
      chk("done",         done,         m_state == 2);
      chk("timeout",      timeout,      m_state == 3);
      chk("pass",         pass,         ep);
      chk("query_value",  query_value,  m_qv);
      chk("query_stamp",  query_stamp,  m_qs);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      addr = a; wdata = d; wen = w;
      cycle();
      wen = 4'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b0; wen = 4'h0;
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic start();
      enable = 1'b1;
      cycle();
      enable = 1'b0;
   endtask

   task automatic fill_slots(input int skip);
      for (int k = 0; k < N; k++) if (k != skip) bus_write(BASE + 32'(4 * k), 32'h0, 4'hF);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; addr = 0; wdata = 0; wen = 0; qidx = 0;
      idle(2);
      rst_n = 1'b1;
      chk("reset_state", state, 2'd0);
      chk("reset_masks", {written_mask, fail_mask}, '0);
      chk("reset_pass",  pass, 1'b0);

      // 1: all slots zero, then sentinel
      do_reset(); start();
      fill_slots(-1);
      bus_write(DADDR, MAGIC, 4'hF);
      chk("t1_state",   state, 2'd2);
      chk("t1_written", written_mask, 13'h1FFF);
      chk("t1_fail",    fail_mask, 13'h0);
      chk("t1_pass",    pass, 1'b1);
      chk("t1_count",   cycle_count, 16'd14);

      // 2: last value wins; a surviving non-zero fails the run
      do_reset(); start();
      fill_slots(4);
      bus_write(BASE + 32'h10, 32'd7, 4'hF);
      bus_write(BASE + 32'h10, 32'd0, 4'hF);
      qidx = 6'd4;
      idle(1);
      chk("t2_fail_clear", fail_mask, 13'h0);
      chk("t2_query4",     query_value, 32'h0);
      do_reset(); start();
      fill_slots(4);
      bus_write(BASE + 32'h10, 32'd7, 4'hF);
      bus_write(DADDR, MAGIC, 4'hF);
      chk("t2_fail4", fail_mask, 13'h0010);
      chk("t2_pass",  pass, 1'b0);
      chk("t2_state", state, 2'd2);

      // 3: timeout with bounded wait, late sentinel ignored
      do_reset(); start();
      for (int k = 0; k < TO + 100 && timeout !== 1'b1; k++) cycle();
      chk("t3_timeout", timeout, 1'b1);
      chk("t3_count",   cycle_count, 16'd2000);
      chk("t3_pass",    pass, 1'b0);
      bus_write(DADDR, MAGIC, 4'hF);
      chk("t3_state", state, 2'd3);

      // 4: malformed writes and out-of-window writes
      do_reset(); start();
      bus_write(BASE, 32'h0, 4'hF);
      bus_write(BASE + 32'h4, 32'h5, 4'b0011);
      chk("t4_err",     err_write, 1'b1);
      chk("t4_written", written_mask, 13'h0001);
      bus_write(BASE + 32'h6, 32'h5, 4'hF);
      bus_write(BASE + 32'h34, 32'h5, 4'hF);
      bus_write(32'hFC, 32'h5, 4'hF);
      qidx = 6'd1;
      idle(1);
      chk("t4_written2", written_mask, 13'h0001);
      chk("t4_query1",   query_value, 32'h0);

      // 5: sentinel on the last RUN cycle beats timeout; reset mid-run
      do_reset(); start();
      idle(TO - 1);
      bus_write(DADDR, MAGIC, 4'hF);
      chk("t5_state", state, 2'd2);
      chk("t5_count", cycle_count, 16'd2000);
      do_reset(); start();
      bus_write(BASE + 32'h8, 32'h9, 4'hF);
      bus_write(BASE + 32'hC, 32'h9, 4'b0001);
      do_reset();
      chk("t5_rst_state", state, 2'd0);
      chk("t5_rst_masks", {written_mask, fail_mask, err_write}, '0);

      // 6: first-write stamp retained across rewrite
      do_reset(); start();
      idle(37);
      bus_write(BASE + 32'h8, 32'h55, 4'hF);
      idle(52);
      bus_write(BASE + 32'h8, 32'h66, 4'hF);
      qidx = 6'd2;
      idle(1);
      chk("t6_value", query_value, 32'h66);
`ifdef RESULT_MON_STAMP_EN
      chk("t6_stamp", query_stamp, 16'd37);
`else
      chk("t6_stamp", query_stamp, 16'd0);
`endif

      // Randomized traffic
      for (int r = 0; r < 25; r++) begin
         do_reset();
         for (int k = 0; k < int'($urandom_range(40, 300)); k++) begin
            int sel;
            enable = ($urandom_range(0, 3) == 0);
            qidx   = 6'($urandom_range(0, 15));
            sel    = int'($urandom_range(0, 39));
            wen    = 4'hF;
            wdata  = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            if (sel < 24)      addr = BASE + 32'(4 * $urandom_range(0, N - 1));
            else if (sel < 28) begin
               addr = BASE + 32'($urandom_range(0, 4 * N - 1));
               wen  = 4'($urandom_range(0, 15));
            end
            else if (sel < 31) addr = ($urandom_range(0, 1) == 1) ? 32'hFC : BASE + 32'(4 * N);
            else if (sel == 31) begin addr = DADDR; wdata = MAGIC; end
            else if (sel == 32) begin addr = DADDR; wdata = MAGIC ^ 32'h1; end
            else begin addr = $urandom; wen = 4'h0; end
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            cycle();
            rst_n = 1'b1;
            wen   = 4'h0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
